// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the 1xN DeMUX dispatcher and its benches.
//   sw_of()       : select-width helper, $clog2(n) with a floor of 1 bit
//   DEMUX_N/SW    : default channel count and select width
//   demux_item_t  : one routed item (data bit + destination index)
package demux_pkg;

  function automatic int sw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEMUX_N  = 8;
  localparam int DEMUX_SW = sw_of(DEMUX_N);

  typedef struct packed {
    logic                bit_v;
    logic [DEMUX_SW-1:0] dest;
  } demux_item_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy.
//   push/push_data : write an entry (ignored when full)
//   pop            : retire the head entry (ignored when empty)
//   head           : current head entry, valid when !empty
//   count          : number of stored entries, 0..DEPTH
//   full/empty     : occupancy flags derived from count
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset discards all stored entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: buffers (bit, dest) items and presents them one at a time
// to a 1xN DeMUX, holding each until the addressed channel is ready.
//   in_valid/in_ready/in_bit/in_dest : upstream item handshake
//   dest_ready                        : per-channel consumer ready
//   inpt/sel/out_valid                : registered item presented to the DeMUX
//   fill                              : FIFO occupancy (output stage excluded)
//   err_pulse                         : one-cycle pulse when an out-of-range item is dropped
module demux_dispatcher
  import demux_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int DEPTH = 4,
  localparam int SW    = sw_of(N),
  localparam int FW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  input  logic [SW-1:0] in_dest,
  input  logic [N-1:0]  dest_ready,
  output logic          inpt,
  output logic [SW-1:0] sel,
  output logic          out_valid,
  output logic [FW-1:0] fill,
  output logic          err_pulse
);

  typedef struct packed {
    logic          bit_v;
    logic [SW-1:0] dest;
  } item_t;

  localparam logic [SW:0] N_LIM = N[SW:0];

  item_t                in_item_s;
  item_t                head_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [FW-1:0]        fifo_count_s;
  logic [(1<<SW)-1:0]   dr_ext_s;
  logic                 in_ready_s, accept_s, dest_ok_s, push_ok_s;
  logic                 pop_or_s, or_free_s, fifo_pop_s, fifo_push_s, bypass_s;

  logic                 inpt_q, inpt_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_pulse_q, err_pulse_d;

  assign in_item_s.bit_v = in_bit;
  assign in_item_s.dest  = in_dest;

  // No pop-through: a full FIFO refuses input even if the output stage drains.
  assign in_ready_s = rst_n && !fifo_full_s;

  sync_fifo #(
    .WIDTH (SW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_s),
    .push_data (in_item_s),
    .pop       (fifo_pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Handshake, drop check and output-stage load decisions.
  always_comb begin
    // Widen dest_ready to the full select range so unused select codes read 0.
    dr_ext_s        = '0;
    dr_ext_s[N-1:0] = dest_ready;
    accept_s        = in_valid && in_ready_s;
    dest_ok_s       = ({1'b0, in_dest} < N_LIM);
    push_ok_s       = accept_s && dest_ok_s;
    pop_or_s        = out_valid_q && dr_ext_s[sel_q];
    or_free_s       = !out_valid_q || pop_or_s;
    fifo_pop_s      = or_free_s && !fifo_empty_s;
    // Bypass only when nothing is queued, so ordering is preserved.
    bypass_s        = or_free_s && fifo_empty_s && push_ok_s;
    fifo_push_s     = push_ok_s && !bypass_s;
  end

  // Output register next state: FIFO head first, then bypass, else drain or hold.
  always_comb begin
    inpt_d      = inpt_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    err_pulse_d = accept_s && !dest_ok_s;
    if (fifo_pop_s) begin
      inpt_d      = head_s.bit_v;
      sel_d       = head_s.dest;
      out_valid_d = 1'b1;
    end else if (bypass_s) begin
      inpt_d      = in_item_s.bit_v;
      sel_d       = in_item_s.dest;
      out_valid_d = 1'b1;
    end else if (pop_or_s) begin
      // sel keeps its last value so the DeMUX select does not glitch.
      inpt_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      inpt_d      = inpt_q;
      out_valid_d = out_valid_q;
    end
  end

  // Output register and error pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inpt_q      <= 1'b0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      inpt_q      <= inpt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign inpt      = inpt_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign fill      = fifo_count_s;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Testbench for demux_dispatcher: an N=8 instance carries the ordered-delivery
// scenarios through a scoreboard; an N=6 instance covers out-of-range drops.
module tb_demux_dispatcher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready, in_bit = 1'b0;
  logic [2:0] in_dest = 3'd0;
  logic [7:0] dest_ready = 8'hFF;
  logic       inpt, out_valid, err_pulse;
  logic [2:0] sel, fill;

  logic       in_valid6 = 1'b0, in_ready6, in_bit6 = 1'b0;
  logic [2:0] in_dest6 = 3'd0;
  logic [5:0] dest_ready6 = 6'd0;
  logic       inpt6, out_valid6, err_pulse6;
  logic [2:0] sel6, fill6;

  demux_dispatcher #(.N(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_dest(in_dest), .dest_ready(dest_ready),
    .inpt(inpt), .sel(sel), .out_valid(out_valid), .fill(fill),
    .err_pulse(err_pulse)
  );

  demux_dispatcher #(.N(6), .DEPTH(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_bit(in_bit6), .in_dest(in_dest6), .dest_ready(dest_ready6),
    .inpt(inpt6), .sel(sel6), .out_valid(out_valid6), .fill(fill6),
    .err_pulse(err_pulse6)
  );

  typedef struct {
    logic       b;
    logic [2:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one item and hold it until the handshake edge; expected item queued on accept.
  task automatic send(input logic b, input logic [2:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_dest  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept dest=%0d", d);
    end else begin
      exp_q.push_back('{b, d});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare each item as it is popped by its channel.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && dest_ready[sel]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_item actual=bit%0d_sel%0d required=none", inpt, sel);
        end else begin
          e = exp_q.pop_front();
          check("item_bit", {31'd0, inpt}, {31'd0, e.b});
          check("item_sel", {29'd0, sel}, {29'd0, e.d});
        end
      end
      if (!out_valid) check("idle_inpt_zero", {31'd0, inpt}, 32'd0);
    end
  end

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inpt", {31'd0, inpt}, 32'd0);
    check("rst_sel", {29'd0, sel}, 32'd0);
    check("rst_fill", {29'd0, fill}, 32'd0);
    check("rst_err", {31'd0, err_pulse}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: bypass path, one-edge latency
    send(1'b1, 3'd3);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_inpt", {31'd0, inpt}, 32'd1);
    check("t1_sel", {29'd0, sel}, 32'd3);
    check("t1_fill", {29'd0, fill}, 32'd0);
    tick();
    check("t1_drained", {31'd0, out_valid}, 32'd0);
    check("t1_sel_kept", {29'd0, sel}, 32'd3);

    // 2: fill to capacity while blocked, then drain in order
    dest_ready = 8'h00;
    send(1'b1, 3'd0);
    send(1'b0, 3'd1);
    send(1'b1, 3'd2);
    send(1'b1, 3'd3);
    send(1'b1, 3'd4);
    check("t2_fill_full", {29'd0, fill}, 32'd4);
    check("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("t2_head_sel", {29'd0, sel}, 32'd0);
    tick();
    check("t2_still_blocked", {31'd0, in_ready}, 32'd0);
    fork
      send(1'b0, 3'd5);
      begin
        dest_ready = 8'hFF;
        for (int k = 1; k <= 5; k++) begin
          tick();
          check("t2_seq_sel", {29'd0, sel}, k);
        end
      end
    join
    tick();
    check("t2_empty", {31'd0, out_valid}, 32'd0);

    // 3: head-of-line blocking
    dest_ready = 8'h00;
    send(1'b1, 3'd2);
    send(1'b1, 3'd5);
    dest_ready = 8'b0010_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hol_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hol_sel", {29'd0, sel}, 32'd2);
      check("t3_hol_fill", {29'd0, fill}, 32'd1);
    end
    dest_ready = 8'b0010_0100;
    tick();
    check("t3_next_sel", {29'd0, sel}, 32'd5);
    check("t3_next_fill", {29'd0, fill}, 32'd0);
    tick();
    check("t3_empty", {31'd0, out_valid}, 32'd0);

    // 4: full with simultaneous pop, no pop-through
    dest_ready = 8'h00;
    send(1'b0, 3'd6);
    send(1'b1, 3'd7);
    send(1'b0, 3'd0);
    send(1'b1, 3'd1);
    send(1'b0, 3'd2);
    check("t4_full", {29'd0, fill}, 32'd4);
    fork
      send(1'b1, 3'd3);
      begin
        dest_ready = 8'hFF;
        check("t4_no_pop_through", {31'd0, in_ready}, 32'd0);
        tick();
        check("t4_fill_after_pop", {29'd0, fill}, 32'd3);
        check("t4_ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        check("t4_fill_push_pop", {29'd0, fill}, 32'd3);
      end
    join
    repeat (6) tick();
    check("t4_drained_valid", {31'd0, out_valid}, 32'd0);
    check("t4_drained_fill", {29'd0, fill}, 32'd0);
    check("t4_scoreboard_empty", exp_q.size(), 32'd0);

    // 5: N=6 drop of out-of-range destinations
    in_valid6 = 1'b1;
    in_bit6   = 1'b1;
    in_dest6  = 3'd7;
    check("t5_ready", {31'd0, in_ready6}, 32'd1);
    tick();
    in_valid6 = 1'b0;
    check("t5_err_set", {31'd0, err_pulse6}, 32'd1);
    check("t5_no_out", {31'd0, out_valid6}, 32'd0);
    check("t5_fill", {29'd0, fill6}, 32'd0);
    tick();
    check("t5_err_clear", {31'd0, err_pulse6}, 32'd0);
    check("t5_still_no_out", {31'd0, out_valid6}, 32'd0);
    in_valid6 = 1'b1;
    in_bit6   = 1'b0;
    in_dest6  = 3'd5;
    tick();
    in_dest6  = 3'd6;
    check("t5_legal_valid", {31'd0, out_valid6}, 32'd1);
    check("t5_legal_sel", {29'd0, sel6}, 32'd5);
    check("t5_legal_err", {31'd0, err_pulse6}, 32'd0);
    tick();
    in_valid6 = 1'b0;
    check("t5_drop6_err", {31'd0, err_pulse6}, 32'd1);
    check("t5_drop6_fill", {29'd0, fill6}, 32'd0);
    check("t5_drop6_sel", {29'd0, sel6}, 32'd5);

    // 6: asynchronous reset mid-stream
    dest_ready = 8'h00;
    send(1'b1, 3'd1);
    send(1'b1, 3'd2);
    send(1'b0, 3'd3);
    send(1'b1, 3'd4);
    check("t6_fill", {29'd0, fill}, 32'd3);
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_inpt", {31'd0, inpt}, 32'd0);
    check("t6_async_sel", {29'd0, sel}, 32'd0);
    check("t6_async_fill", {29'd0, fill}, 32'd0);
    check("t6_async_ready", {31'd0, in_ready}, 32'd0);
    check("t6_async_valid6", {31'd0, out_valid6}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_rel_ready", {31'd0, in_ready}, 32'd1);
    check("t6_rel_fill", {29'd0, fill}, 32'd0);
    dest_ready = 8'hFF;
    repeat (4) tick();
    check("t6_no_stale", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
